// File: rtl/result_stream_pkg.sv
// Shared definitions for the result return path: cfg address map, FSM
// state encoding and a small sizing helper.
package result_stream_pkg;

    // Cfg register address for the layer word count. The image write/read
    // registers sit at addresses 0 and 1 of the same map.
    localparam int CFG_RES_NB = 2;

    // Layer control states with fixed encodings.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    // Width of a beat index; at least one bit, even with one beat per word.
    function automatic int beat_idx_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/result_stream_fifo.sv
// Synchronous FIFO with a registered read port and count-based full/empty
// flags. A read presents the head word on rd_data after the clock edge.
module fifo_sync #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [AWIDTH:0]   count
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign full  = (count == (AWIDTH + 1)'(DEPTH));
    assign empty = (count == '0);

    // Storage array write.
    // NOTE: the array is deliberately not reset; the pointers and count
    // decide which entries are meaningful, and a reset port on every word
    // would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AWIDTH'(1);
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + AWIDTH'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AWIDTH + 1)'(1);
                2'b01:   count <= count - (AWIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_stream.sv
// Result return path: buffers result words from the compute array, splits
// each into host-width beats and closes every layer with last + done after
// the word count programmed over cfg.
module result_stream
    import result_stream_pkg::*;
#(
    parameter int CFG_DWIDTH    = 32,
    parameter int CFG_AWIDTH    = 5,
    parameter int GROUP_NB      = 4,
    parameter int IMG_WIDTH     = 16,
    parameter int STR_RES_WIDTH = 32,
    parameter int FIFO_AWIDTH   = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_DWIDTH-1:0]         cfg_data,
    input  logic [CFG_AWIDTH-1:0]         cfg_addr,
    input  logic                          cfg_valid,
    input  logic [GROUP_NB*IMG_WIDTH-1:0] layer_bus,
    input  logic                          layer_last,
    input  logic                          layer_val,
    output logic                          layer_rdy,
    output logic [STR_RES_WIDTH-1:0]      str_res_bus,
    output logic                          str_res_last,
    output logic                          str_res_val,
    input  logic                          str_res_rdy,
    output logic                          res_done,
    output logic                          res_err
);

    localparam int WORD_W = GROUP_NB * IMG_WIDTH;
    localparam int BEATS  = WORD_W / STR_RES_WIDTH;
    localparam int BEAT_W = beat_idx_width(BEATS);
    localparam int DEPTH  = 1 << FIFO_AWIDTH;
    localparam int OCC_W  = FIFO_AWIDTH + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt_max;
    logic [CNT_WIDTH-1:0] word_cnt;

    logic                 fifo_rd;
    logic [WORD_W-1:0]    fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AWIDTH:0] fifo_count;

    logic                 rd_val;     // fifo_rd_data holds a popped word
    logic [WORD_W-1:0]    sh_reg;
    logic                 sh_val;
    logic [BEAT_W-1:0]    beat_idx;

    logic                 cfg_fire;
    logic                 in_fire;
    logic                 is_tag;
    logic                 beat_fire;
    logic                 word_done;
    logic                 sh_load;
    logic                 final_word;
    logic                 layer_done;
    logic [OCC_W-1:0]     occ;
    logic                 buf_full;

    // Upper cfg data bits carry no meaning for this register.
    if (CFG_DWIDTH > CNT_WIDTH) begin : g_cfg_hi
        logic unused_cfg_hi;
        assign unused_cfg_hi = ^cfg_data[CFG_DWIDTH-1:CNT_WIDTH];
    end

    assign cfg_fire = cfg_valid && (state == ST_IDLE)
                   && (cfg_addr == CFG_AWIDTH'(CFG_RES_NB))
                   && (cfg_data[CNT_WIDTH-1:0] != '0);
    assign in_fire  = layer_val && layer_rdy;
    assign is_tag   = (word_cnt == cnt_max - CNT_WIDTH'(1));

    // Capacity covers every word held between input and output: FIFO,
    // the popped read register and the word being serialised.
    assign occ      = OCC_W'(fifo_count) + OCC_W'(rd_val) + OCC_W'(sh_val);
    assign buf_full = fifo_full || (occ >= OCC_W'(DEPTH));

    assign beat_fire = sh_val && str_res_rdy;
    assign word_done = beat_fire && (beat_idx == LAST_BEAT);
    assign sh_load   = rd_val && (!sh_val || word_done);
    assign fifo_rd   = !fifo_empty && (!rd_val || sh_load);

    // Input stops at the tagged word, so once draining with nothing behind
    // the shift register it must hold the tagged word.
    assign final_word   = (state == ST_DRAIN) && fifo_empty && !rd_val;
    assign str_res_last = sh_val && (beat_idx == LAST_BEAT) && final_word;
    assign str_res_val  = sh_val;
    assign str_res_bus  = sh_reg[STR_RES_WIDTH-1:0];
    assign layer_done   = str_res_last && str_res_rdy;

    fifo_sync #(
        .DWIDTH (WORD_W),
        .AWIDTH (FIFO_AWIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_fire),
        .wr_data (layer_bus),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and upstream ready.
    // NOTE: defaults are assigned first so no path leaves an output
    // unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        layer_rdy = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_fire) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                layer_rdy = !buf_full;
                if (layer_val && !buf_full && is_tag) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (layer_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Layer count, word count and sticky framing error.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_max  <= '0;
            word_cnt <= '0;
            res_err  <= 1'b0;
        end else if (cfg_fire) begin
            cnt_max  <= cfg_data[CNT_WIDTH-1:0];
            word_cnt <= '0;
            res_err  <= 1'b0;
        end else if (in_fire) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
            if (layer_last != is_tag) begin
                res_err <= 1'b1;
            end
        end
    end

    // Serialiser: read-register staging, shift register, beat index, done.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_val   <= 1'b0;
            sh_reg   <= '0;
            sh_val   <= 1'b0;
            beat_idx <= '0;
            res_done <= 1'b0;
        end else begin
            res_done <= layer_done;
            if (fifo_rd) begin
                rd_val <= 1'b1;
            end else if (sh_load) begin
                rd_val <= 1'b0;
            end
            if (sh_load) begin
                sh_reg   <= fifo_rd_data;
                sh_val   <= 1'b1;
                beat_idx <= '0;
            end else if (word_done) begin
                sh_val   <= 1'b0;
                beat_idx <= '0;
            end else if (beat_fire) begin
                sh_reg   <= sh_reg >> STR_RES_WIDTH;
                beat_idx <= beat_idx + BEAT_W'(1);
            end
        end
    end

endmodule
